mul_32b: RTL and testbench
==========================

# mul_32b

Sequential 32×32 shift-add multiplier producing a 64-bit product, signed or unsigned. It is the inverse companion of the `div_32b` divider in the Division project. It uses the same start/ready handshake, so one initiator or bench can drive either unit and cross-check a = quot·b + rem. One product bit-step runs per clock, with a fixed, data-independent latency.

## Interface
- `WIDTH`, default 32: operand width; the product is 2·`WIDTH`.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `a`  input  WIDTH  multiplicand; sampled only at launch.
- `b`  input  WIDTH  multiplier; sampled only at launch.
- `sign`  input  1  1 = two's-complement operands, 0 = unsigned; sampled only at launch.
- `start`  input  1  launch request; sampled only while idle.
- `hi`  output  WIDTH  upper half of the product.
- `lo`  output  WIDTH  lower half of the product.
- `ready`  output  1  1 = idle, with `hi`/`lo` holding the last result.

## Operation
- The state machine has three states: IDLE, BUSY and FIX.
- **IDLE**
  - `ready`=1.
  - A rising edge with `start`=1 launches an operation:
    - latch the magnitudes of `a` and `b` (absolute value if `sign`=1, raw value otherwise);
    - latch `neg` = `sign` & (a[MSB] ^ b[MSB]);
    - clear the 2·WIDTH accumulator and the iteration counter;
    - go to BUSY.
- **BUSY**, one step per edge:
  - if multiplier LSB=1, add the multiplicand into the accumulator upper half, with carry kept;
  - shift accumulator and multiplier right by 1;
  - increment the counter.
  - After the WIDTH-th step, go to FIX.
- **FIX**
  - Write `{hi,lo}` = `neg` ? −acc : acc, using 2·WIDTH two's-complement negation.
  - Go to IDLE.
- Arithmetic and width rules:
  - The magnitude of the most-negative value (0x80000000) is 0x80000000, treated as unsigned. The product is exact; no overflow is possible in 2·WIDTH bits.
  - The accumulator adder is WIDTH+1 bits wide so the carry out is not lost.
- Operand stability:
  - `a`, `b` and `sign` are don't-care outside the launch edge.
  - Changes during BUSY or FIX have no effect.
- `start` handling outside IDLE:
  - `start` asserted during BUSY or FIX is ignored and not queued.
  - `start` still high on the first IDLE edge launches a new operation. The initiator must drop `start` once `ready` falls.
- Zero operands take the full latency; there is no early exit.

## Timing
- Reset values, asynchronous on `rst`=1:
  - state IDLE, `ready`=1, `hi`=0, `lo`=0;
  - counter, accumulator and `neg` cleared.
- Launch edge E0: `ready` reads 0 after E0.
- Result: `hi`/`lo` update and `ready` returns to 1 on the same edge, E0+WIDTH+1 (edge 33 for WIDTH=32). `ready` is low for exactly WIDTH+1 cycles.
- Earliest relaunch is edge E0+WIDTH+2, giving back-to-back throughput of one product per WIDTH+2 cycles.
- `hi`/`lo` change only on the FIX edge or on reset. They are stable throughout BUSY and hold the previous result.
- Reset mid-operation aborts immediately: `ready`=1 and `hi`=`lo`=0. No partial result is ever visible.
- All outputs are registered.

## Structure
- Package `arith_pkg` holds:
  - the state enum {IDLE, BUSY, FIX};
  - the `WIDTH` default of 32;
  - the counter width $clog2(WIDTH+1).
- `div_32b` adopts the same package for its handshake states.
- Sub-module `mul_step` is combinational. It takes accumulator, multiplicand and multiplier-LSB and returns the next accumulator after the add-and-shift. It keeps the datapath separate from the control state machine and is unit-testable on its own.
- The top level holds:
  - the state machine and counter;
  - the magnitude and negation logic;
  - the output registers.

## Test plan
- Reset for 3 cycles, then release → `ready`=1, `hi`=0, `lo`=0 with no `start`.
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF, `sign`=0 → after 33 cycles `hi`=0xFFFFFFFE, `lo`=0x00000001. `ready` is low exactly 33 cycles.
- Signed 0xFFFFFFFD (−3) × 0x00000007, `sign`=1 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. The same operands with `sign`=0 → `hi`=0x00000006, `lo`=0xFFFFFFEB.
- Signed 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0x00000000.
- 0x12345678 × 0, with `a`/`b` toggled randomly during BUSY → `hi`=`lo`=0 after 33 cycles, and the previous result is held until then.
- Assert `rst` on cycle 10 of BUSY → `ready`=1 and `hi`=`lo`=0 immediately. Then 6 × 7, `sign`=0 → `lo`=42, `hi`=0. Finish with 10 random pairs checked against a 64-bit reference model.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic units (multiplier and divider):
// handshake state encoding, default operand width and counter sizing.
package arith_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX
  } state_e;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int CNT_W = cnt_w(WIDTH_DEF);

endpackage

// File: rtl/mul_32b_if.sv
// Start/ready handshake bundle shared by the multiplier and its initiator.
interface mul_32b_if
  import arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sign;
    logic             start;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             ready;

    modport master(output a, b, sign, start, input hi, lo, ready);
    modport slave(input a, b, sign, start, output hi, lo, ready);

endinterface

// File: rtl/mul_step.sv
// One shift-add multiplier bit-step: conditional add into the accumulator upper
// half (carry kept in a WIDTH+1 bit sum), then a right shift of the whole accumulator.
module mul_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [  WIDTH-1:0] mcand_i,
    input  logic               lsb_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (lsb_i ? {1'b0, mcand_i} : '0);
        // The carry becomes the new MSB; the old accumulator LSB falls off.
        acc_o = (2 * WIDTH)'({sum, acc_i[WIDTH-1:0]} >> 1);
    end

endmodule

// File: rtl/mul_32b.sv
// Sequential signed/unsigned WIDTHxWIDTH multiplier: magnitudes are multiplied
// by shift-add over WIDTH cycles, then the sign is applied in a single FIX cycle.
module mul_32b
  import arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic clk,
    input logic rst,
    mul_32b_if.slave bus
);

    localparam int CW = cnt_w(WIDTH);

    state_e                 state_q, state_d;
    logic   [       CW-1:0] cnt_q, cnt_d;
    logic   [  2*WIDTH-1:0] acc_q, acc_d;
    logic   [    WIDTH-1:0] mcand_q, mcand_d;
    logic   [    WIDTH-1:0] mplier_q, mplier_d;
    logic   [    WIDTH-1:0] hi_q, hi_d;
    logic   [    WIDTH-1:0] lo_q, lo_d;
    logic                   neg_q, neg_d;
    logic                   ready_q, ready_d;

    logic   [    WIDTH-1:0] mag_a;
    logic   [    WIDTH-1:0] mag_b;
    logic   [  2*WIDTH-1:0] acc_step;
    logic   [  2*WIDTH-1:0] result;

    mul_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc_i  (acc_q),
        .mcand_i(mcand_q),
        .lsb_i  (mplier_q[0]),
        .acc_o  (acc_step)
    );

    // Negating the most-negative value wraps back to itself, which is exactly
    // the correct unsigned magnitude.
    always_comb begin
        mag_a  = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        mag_b  = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        result = neg_q ? -acc_q : acc_q;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_d    = neg_q;
        ready_d  = ready_q;

        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.start) begin
                    mcand_d  = mag_a;
                    mplier_d = mag_b;
                    neg_d    = bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    ready_d  = 1'b0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                acc_d    = acc_step;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                {hi_d, lo_d} = result;
                ready_d      = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q    <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_q    <= neg_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_mul_32b.sv
// Self-checking bench for mul_32b: directed corner products, operand churn during
// BUSY, mid-operation reset and random pairs against a 64-bit arithmetic model.
module tb_mul_32b;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail = 0;

    mul_32b_if #(.WIDTH(32)) bus ();

    mul_32b #(
        .WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Launch one product, churn operands while busy, then check latency,
    // output hold, result and that nothing relaunches afterwards.
    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [63:0] exp, input bit poke_start);
        logic [63:0] prev;
        int          cnt;
        int          held_bad;
        prev = {bus.hi, bus.lo};
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.sign  = s;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cnt       = 0;
        held_bad  = 0;
        while (!bus.ready && cnt < 200) begin
            cnt++;
            if ({bus.hi, bus.lo} !== prev) held_bad++;
            bus.a     = $urandom;
            bus.b     = $urandom;
            bus.sign  = 1'($urandom);
            bus.start = poke_start && (cnt == 5);
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, "_ready_low_cycles"}, 64'(cnt), 64'd33);
        check({tag, "_held_during_busy"}, 64'(held_bad), 64'd0);
        check({tag, "_model"}, {bus.hi, bus.lo}, ref_mul(a, b, s));
        check({tag, "_expected"}, {bus.hi, bus.lo}, exp);
        @(negedge clk);
        check({tag, "_stays_idle"}, 64'(bus.ready), 64'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        rst       = 1'b1;
        bus.a     = '0;
        bus.b     = '0;
        bus.sign  = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", 64'(bus.ready), 64'd1);
        check("reset_result", {bus.hi, bus.lo}, 64'd0);

        run("u_ff_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0);
        run("s_m3_7", 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        run("u_m3_7", 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 64'h0000_0006_FFFF_FFEB, 1'b0);
        run("s_min_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b0);
        run("zero_churn", 32'h1234_5678, 32'h0000_0000, 1'b0, 64'd0, 1'b1);
        run("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000, 1'b0);

        // Abort an operation 10 cycles into BUSY with a nonzero result on show.
        @(negedge clk);
        bus.a     = 32'd1234;
        bus.b     = 32'd5678;
        bus.sign  = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("pre_abort_result", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_ready", 64'(bus.ready), 64'd1);
        check("abort_result", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run("u_6_7", 32'd6, 32'd7, 1'b0, 64'd42, 1'b0);

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            run($sformatf("rand%0d", i), ra, rb, rs, ref_mul(ra, rb, rs), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
